// File: rtl/simple_fifo_flex.sv
// ---------------------------------------------------------------------------
// simple_fifo_flex
//
// Parametrised synchronous FIFO that sits between Synthesijer-generated
// modules and stream HDL. It offers a standard registered read port or a
// first-word-fall-through read port, programmable almost-full/almost-empty
// thresholds, a synchronous flush and sticky overflow/underflow flags.
//
// Parameters:
//   WIDTH      data width in bits
//   DEPTH_LOG  log2 of the number of entries (depth D = 2**DEPTH_LOG)
//   FWFT       0 = registered read, 1 = first-word-fall-through
//   AFULL_TH   almost_full  when count >= AFULL_TH
//   AEMPTY_TH  almost_empty when count <= AEMPTY_TH
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset, discards all contents
//   flush         synchronous clear of contents and flags
//   we / din      write request and write data
//   re            read request (in FWFT mode it pops the displayed word)
//   dout / valid  read data and its qualifier
//   empty / full  occupancy status
//   almost_empty  count <= AEMPTY_TH
//   almost_full   count >= AFULL_TH
//   count         number of stored words, 0 to D
//   overflow      sticky, a write was dropped
//   underflow     sticky, a read was ignored
// ---------------------------------------------------------------------------
module simple_fifo_flex #(
    parameter int WIDTH     = 256,
    parameter int DEPTH_LOG = 3,
    parameter int FWFT      = 0,
    parameter int AFULL_TH  = (1 << DEPTH_LOG) - 1,
    parameter int AEMPTY_TH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 we,
    input  logic [WIDTH-1:0]     din,
    input  logic                 re,
    output logic [WIDTH-1:0]     dout,
    output logic                 valid,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full,
    output logic [DEPTH_LOG:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int                 DEPTH    = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_C  = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] AFULL_C  = (DEPTH_LOG + 1)'(AFULL_TH);
    localparam logic [DEPTH_LOG:0] AEMPTY_C = (DEPTH_LOG + 1)'(AEMPTY_TH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 rd_acc;
    logic                 wr_acc;
    logic [DEPTH_LOG:0]   count_nxt;

    // A read needs a stored word; there is no bypass from din. A write to a
    // full FIFO still goes through when a read frees a slot in the same cycle.
    assign rd_acc = re && !empty;
    assign wr_acc = we && (!full || rd_acc);

    // Next occupancy. Flush empties the FIFO and discards that cycle's
    // requests; simultaneous read and write leave the count unchanged.
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count - 1'b1;
        end
    end

    // Pointers, count and all status flags. Flags are registered from the
    // next-state count so they always agree with count in the same cycle.
    // The error flags are sticky until reset or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == DEPTH_C);
            almost_empty <= (count_nxt <= AEMPTY_C);
            almost_full  <= (count_nxt >= AFULL_C);
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_acc) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (we && !wr_acc) begin
                    overflow <= 1'b1;
                end
                if (re && empty) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

    // Storage array. It is deliberately not reset; only accepted writes
    // outside flush and reset touch it.
    always_ff @(posedge clk) begin
        if (!reset && !flush && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head word is shown combinationally; re acknowledges it.
            assign dout  = mem[rd_ptr];
            assign valid = !empty;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic             valid_q;

            // Registered read port: an accepted read loads the head word and
            // raises valid for one cycle; otherwise dout holds its value.
            // Flush drops valid but keeps the last word on dout.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= mem[rd_ptr];
                    end
                end
            end

            assign dout  = dout_q;
            assign valid = valid_q;
        end
    endgenerate

endmodule
